// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_add_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Existing 4-bit ripple-carry adder reused as the serial datapath.
module fourbitfulladder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic carry;

   always_comb begin
      carry = cin;
      sum   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit adder,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t               state, state_nx;
   logic [WIDTH-1:0]     a_sh, b_sh, res;
   logic                 carry;
   logic [CNT_W-1:0]     cnt;
   logic [NIBBLE_W-1:0]  nib;
   logic                 nib_cout;
   logic                 last;

   fourbitfulladder u_add (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (b_sh[NIBBLE_W-1:0]),
      .cin  (carry),
      .sum  (nib),
      .cout (nib_cout)
   );

   assign last = (cnt == CNT_W'(NIBBLES - 1));
   assign sum  = res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Result fills from the MSB end so after NIBBLES passes nibble 0 lands in res[3:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               res   <= (res >> NIBBLE_W) | (WIDTH'(nib) << (WIDTH - NIBBLE_W));
               a_sh  <= a_sh >> NIBBLE_W;
               b_sh  <= b_sh >> NIBBLE_W;
               carry <= nib_cout;
               cnt   <= cnt + CNT_W'(1);
               if (last) cout <= nib_cout;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: directed scenarios plus a randomized stream against an arithmetic model.
module tb_nibble_serial_add_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [15:0] a, b, sum;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
   logic [3:0]  a4, b4, sum4;

   int checks   = 0;
   int failures = 0;

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                           input logic c);
      return {1'b0, x} + {1'b0, y} + 17'(c);
   endfunction

   // Present an operand set until accepted; returns at #1 after the accepting edge.
   task automatic accept16(input logic [15:0] x, input logic [15:0] y, input logic c,
                           output bit ok);
      a = x; b = y; cin = c; in_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out16(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) n = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
      checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      bit ok; int n; logic [16:0] e;
      out_ready = 1'b1;
      e = ref_add(16'h1234, 16'h4321, 1'b0);
      accept16(16'h1234, 16'h4321, 1'b0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_accept got=timeout exp=accepted"); end
      wait_out16(n);
      checks++; if (n != 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", n); end
      checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL basic_result got=%b_%h exp=%b_%h", cout, sum, e[16], e[15:0]); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL basic_return_idle got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_carry;
      logic [15:0] xa [2] = '{16'hFFFF, 16'hFFFF};
      logic [15:0] xb [2] = '{16'h0001, 16'h0000};
      logic        xc [2] = '{1'b0, 1'b1};
      bit ok; int n; logic [16:0] e;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         e = ref_add(xa[i], xb[i], xc[i]);
         accept16(xa[i], xb[i], xc[i], ok);
         wait_out16(n);
         checks++; if (!ok || n != 4 || {cout, sum} !== e) begin
            failures++;
            $display("FAIL carry_%0d got=%b_%h lat=%0d exp=%b_%h lat=4", i, cout, sum, n, e[16], e[15:0]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      bit ok; int n; logic [16:0] e; int bad;
      out_ready = 1'b0;
      e = ref_add(16'hABCD, 16'h9876, 1'b1);
      accept16(16'hABCD, 16'h9876, 1'b1, ok);
      wait_out16(n);
      checks++; if (!ok || n != 4 || {cout, sum} !== e) begin
         failures++; $display("FAIL stall_first got=%b_%h lat=%0d exp=%b_%h lat=4", cout, sum, n, e[16], e[15:0]);
      end
      a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== e) bad++;
      end
      checks++; if (bad != 0) begin
         failures++; $display("FAIL stall_hold got=%0d bad cycles, last %b_%h ov=%b ir=%b exp=0 bad", bad, cout, sum, out_valid, in_ready);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL stall_release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_no_accept got busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid_run;
      bit ok; int n; int seen;
      out_ready = 1'b1;
      accept16(16'hFFFF, 16'hFFFF, 1'b1, ok);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0) begin
         failures++; $display("FAIL midrun_reset got busy=%b ir=%b ov=%b sum=%h cout=%b exp 0/1/0/0000/0", busy, in_ready, out_valid, sum, cout);
      end
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrun_no_output got=%0d exp=0", seen); end
      accept16(16'h00FF, 16'h0001, 1'b0, ok);
      wait_out16(n);
      checks++; if (!ok || {cout, sum} !== 17'h00100) begin
         failures++; $display("FAIL midrun_next got=%b_%h exp=0_0100", cout, sum);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [16:0] expq [$];
      logic [16:0] e;
      int sent = 0, recv = 0, cyc = 0;
      bit hs_in, hs_out;
      logic [16:0] got;
      while (recv < 200 && cyc < 20000) begin
         if (sent < 200) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         hs_in  = in_valid && in_ready;
         hs_out = out_valid && out_ready;
         got    = {cout, sum};
         if (hs_in) begin
            expq.push_back(ref_add(a, b, cin));
            sent++;
         end
         if (hs_out) begin
            checks++;
            if (expq.size() == 0) begin
               failures++; $display("FAIL stream_extra got=%b_%h exp=no result", got[16], got[15:0]);
            end else begin
               e = expq.pop_front();
               if (got !== e) begin
                  failures++; $display("FAIL stream_%0d got=%b_%h exp=%b_%h", recv, got[16], got[15:0], e[16], e[15:0]);
               end
            end
            recv++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (recv != 200 || expq.size() != 0) begin
         failures++; $display("FAIL stream_count got recv=%0d pending=%0d exp recv=200 pending=0", recv, expq.size());
      end
   endtask

   task automatic test_width4;
      logic [4:0] e;
      a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1; out_ready4 = 1'b1;
      e = {1'b0, a4} + {1'b0, b4} + 5'(cin4);
      checks++; if (in_ready4 !== 1'b1) begin failures++; $display("FAIL w4_ready got=%b exp=1", in_ready4); end
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid4 !== 1'b1 || {cout4, sum4} !== e) begin
         failures++; $display("FAIL w4_result got ov=%b %b_%h exp ov=1 %b_%h", out_valid4, cout4, sum4, e[4], e[3:0]);
      end
      @(posedge clk); #1;
      checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
         failures++; $display("FAIL w4_idle got ov=%b ir=%b exp 0/1", out_valid4, in_ready4);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_carry;
      test_backpressure;
      test_reset_mid_run;
      test_back_to_back;
      test_width4;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
